// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned PC_STEP      = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; flush has priority over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  entry_t wdata_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign rdata_o = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush_i && w_push) r_mem[r_wptr] <= wdata_i;
    end

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage with prefetch queue. Optional macro FETCH_STALL_CNT_EN adds
// stall_cnt_o, a saturating count of full-and-not-draining cycles.
module fetch_buffered
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    entry_t          w_wdata;
    entry_t          w_head;

    assign w_pc_plus4  = r_pc + XLEN'(PC_STEP);
    assign imem_addr_o = r_pc;
    assign w_pop       = instr_valid_o & instr_ready_i;
    assign w_push      = ~redirect_i & (~w_full | w_pop);
    assign w_wdata     = '{instr: imem_rdata_i, pc: r_pc, pc_plus4: w_pc_plus4};

    always_ff @(posedge clk) begin
        if (!rst)            r_pc <= RESET_PC;
        else if (redirect_i) r_pc <= redirect_pc_i;
        else if (w_push)     r_pc <= w_pc_plus4;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .wdata_i (w_wdata),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign instr_valid_o = ~w_empty;
    assign instr_o       = instr_valid_o ? w_head.instr    : '0;
    assign pc_o          = instr_valid_o ? w_head.pc       : '0;
    assign pc_plus4_o    = instr_valid_o ? w_head.pc_plus4 : '0;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_full && !w_pop && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
